contador_vga: RTL and testbench

Pixel/line timing generator for the VGA path. Divides the system clock into a pixel-rate tick and maintains the horizontal pixel counter and vertical line counter that drive the downstream sync/blank controller, i.e. the `pixel_num` / `linea_num` pair it compares against its porch and sync thresholds. Also flags end-of-line, end-of-frame and the active-video region for the frame-buffer read side.

---
 rtl/contador_vga.sv | 105 ++++++++++
 tb/tb_contador_vga.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/contador_vga.sv
// Pixel/line timing generator: prescaled pixel tick plus horizontal/vertical counters.
// Optional frame counter on num_cuadro is built only when CONTADOR_CUADROS_EN is defined.
module contador_vga #(
  parameter int H_TOTAL   = 800,
  parameter int V_TOTAL   = 525,
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480,
  parameter int DIV       = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        reinicio,
  output logic [0:9]  pixel_num,
  output logic [0:8]  linea_num,
  output logic        pixel_tick,
  output logic        fin_linea,
  output logic        fin_cuadro,
  output logic        visible,
  output logic [0:7]  num_cuadro
);

  localparam logic [3:0] PRE_MAX = 4'(DIV - 1);
  localparam logic [9:0] H_MAX   = 10'(H_TOTAL - 1);
  localparam logic [8:0] V_MAX   = 9'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
  localparam logic [8:0] V_VIS   = 9'(V_VISIBLE);

  logic [3:0] pre_q, pre_d;
  logic [9:0] pix_q, pix_d;
  logic [8:0] lin_q, lin_d;
  logic       tick;
  logic       end_line;
  logic       end_frame;

  // With DIV=1 pre never leaves 0, so this decode reduces to tick = en.
  assign tick      = en && (pre_q == PRE_MAX);
  assign end_line  = tick && (pix_q == H_MAX);
  assign end_frame = end_line && (lin_q == V_MAX);

  always_comb begin
    pre_d = pre_q;
    pix_d = pix_q;
    lin_d = lin_q;
    if (reinicio) begin
      pre_d = '0;
      pix_d = '0;
      lin_d = '0;
    end else if (en) begin
      pre_d = (pre_q == PRE_MAX) ? 4'd0 : pre_q + 4'd1;
      if (tick) begin
        if (pix_q == H_MAX) begin
          pix_d = '0;
          lin_d = (lin_q == V_MAX) ? 9'd0 : lin_q + 9'd1;
        end else begin
          pix_d = pix_q + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      pix_q <= '0;
      lin_q <= '0;
    end else begin
      pre_q <= pre_d;
      pix_q <= pix_d;
      lin_q <= lin_d;
    end
  end

`ifdef CONTADOR_CUADROS_EN
  logic [7:0] num_q, num_d;

  // A restart edge neither clears nor advances the frame count.
  always_comb begin
    num_d = num_q;
    if (!reinicio && end_frame) begin
      num_d = num_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q <= '0;
    end else begin
      num_q <= num_d;
    end
  end

  assign num_cuadro = num_q;
`else
  assign num_cuadro = 8'd0;
`endif

  assign pixel_num  = pix_q;
  assign linea_num  = lin_q;
  assign pixel_tick = tick;
  assign fin_linea  = end_line;
  assign fin_cuadro = end_frame;
  assign visible    = (pix_q < H_VIS) && (lin_q < V_VIS);

endmodule

// File: tb/tb_contador_vga.sv
// Directed bench: default-size generator for tick/line/freeze/restart behaviour,
// plus a small DIV=1 instance for frame wrap, frame period and the frame counter.
module tb_contador_vga;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a_n, en_a, rein_a;
  logic [0:9] pix_a;
  logic [0:8] lin_a;
  logic       tick_a, fl_a, fc_a, vis_a;
  logic [0:7] num_a;

  logic       rst_b_n, en_b, rein_b;
  logic [0:9] pix_b;
  logic [0:8] lin_b;
  logic       tick_b, fl_b, fc_b, vis_b;
  logic [0:7] num_b;

  int checks = 0;
  int errors = 0;

  contador_vga dut_a (
    .clk(clk), .rst_n(rst_a_n), .en(en_a), .reinicio(rein_a),
    .pixel_num(pix_a), .linea_num(lin_a), .pixel_tick(tick_a),
    .fin_linea(fl_a), .fin_cuadro(fc_a), .visible(vis_a), .num_cuadro(num_a)
  );

  contador_vga #(.H_TOTAL(8), .V_TOTAL(4), .H_VISIBLE(5), .V_VISIBLE(3), .DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .en(en_b), .reinicio(rein_b),
    .pixel_num(pix_b), .linea_num(lin_b), .pixel_tick(tick_b),
    .fin_linea(fl_b), .fin_cuadro(fc_b), .visible(vis_b), .num_cuadro(num_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_num(input int frames);
`ifdef CONTADOR_CUADROS_EN
    return frames % 256;
`else
    return 0;
`endif
  endfunction

  // Advance on negedges until dut_a sits at (p,l); lands on the first cycle there.
  task automatic wait_pos(input int p, input int l, input int max_cyc);
    int n = 0;
    while (!(pix_a == p && lin_a == l) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("reach_%0d_%0d", p, l), int'(pix_a == p && lin_a == l), 1);
  endtask

  initial begin
    int held;
    int cyc, pulses, last;
    rst_a_n = 1'b0; en_a = 1'b1; rein_a = 1'b0;
    rst_b_n = 1'b0; en_b = 1'b1; rein_b = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_pix", pix_a, 0);
    check("rst_lin", lin_a, 0);
    check("rst_tick", tick_a, 0);
    check("rst_vis", vis_a, 1);
    check("rst_num", num_a, 0);

    rst_a_n = 1'b1;
    #1;
    check("c0_pix", pix_a, 0);
    check("c0_tick", tick_a, 0);
    @(negedge clk);
    check("c1_tick", tick_a, 1);
    check("c1_pix", pix_a, 0);
    @(negedge clk);
    check("c2_pix", pix_a, 1);
    check("c2_tick", tick_a, 0);

    wait_pos(639, 10, 20000);
    check("vis_639", vis_a, 1);
    wait_pos(640, 10, 10);
    check("vis_640", vis_a, 0);
    wait_pos(799, 10, 400);
    check("vis_799", vis_a, 0);
    check("fl_pre0", fl_a, 0);
    @(negedge clk);
    check("fl_tick", fl_a, 1);
    check("fc_line10", fc_a, 0);
    @(negedge clk);
    check("wrap_pix", pix_a, 0);
    check("wrap_lin", lin_a, 11);
    check("wrap_vis", vis_a, 1);
    check("wrap_fl", fl_a, 0);

    wait_pos(300, 11, 1000);
    @(negedge clk);
    check("frz_pre_tick", tick_a, 1);
    en_a = 1'b0;
    #1;
    check("frz_tick0", tick_a, 0);
    held = 1;
    repeat (37) begin
      @(negedge clk);
      if (!(pix_a == 300 && lin_a == 11 && tick_a == 1'b0 && fl_a == 1'b0)) held = 0;
    end
    check("frz_held", held, 1);
    en_a = 1'b1;
    #1;
    check("resume_tick", tick_a, 1);
    @(negedge clk);
    check("resume_pix", pix_a, 301);
    check("resume_tick_off", tick_a, 0);
    @(negedge clk);
    check("resume_tick_on", tick_a, 1);

    wait_pos(500, 11, 1000);
    @(negedge clk);
    check("rein_tick", tick_a, 1);
    rein_a = 1'b1;
    @(negedge clk);
    rein_a = 1'b0;
    check("rein_pix", pix_a, 0);
    check("rein_lin", lin_a, 0);
    #1;
    check("rein_pre0", tick_a, 0);
    @(negedge clk);
    check("rein_pre1", tick_a, 1);
    @(negedge clk);
    check("rein_step", pix_a, 1);

    wait_pos(5, 0, 50);
    #2;
    rst_a_n = 1'b0;
    #1;
    check("async_pix", pix_a, 0);
    check("async_lin", lin_a, 0);
    check("async_tick", tick_a, 0);
    check("async_vis", vis_a, 1);
    @(negedge clk);
    check("async_hold", pix_a, 0);
    rst_a_n = 1'b1;

    rst_b_n = 1'b1;
    #1;
    check("b_tick", tick_b, 1);
    cyc = 0; pulses = 0; last = 0;
    while (pulses < 257 && cyc < 257 * 32 + 64) begin
      if (fc_b) begin
        if (pulses > 0) check("frame_period", cyc - last, 32);
        check("fc_pix", pix_b, 7);
        check("fc_lin", lin_b, 3);
        check("num_at_fc", num_b, exp_num(pulses));
        last = cyc;
        pulses++;
        @(negedge clk);
        cyc++;
        check("fc_one_cycle", fc_b, 0);
        check("fc_org", pix_b * 16 + lin_b, 0);
        check("num_after_fc", num_b, exp_num(pulses));
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("frames_seen", pulses, 257);

    cyc = 0;
    while (!fc_b && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check("b_fc_found", fc_b, 1);
    rein_b = 1'b1;
    @(negedge clk);
    rein_b = 1'b0;
    check("rein_num_hold", num_b, exp_num(pulses));
    check("rein_b_org", pix_b * 16 + lin_b, 0);
    en_b = 1'b0;
    #1;
    check("b_en0_tick", tick_b, 0);
    check("b_en0_fl", fl_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
